spike_synapse: RTL and testbench
================================

// Module: spike_synapse
// PURPOSE
//  Receiving end of the spike interface: turns a presynaptic 1-bit spike train
//  into the 8-bit synaptic current Isyn that drives a downstream lif neuron.
//  - Each spike adds a programmable weight to the current.
//  - The current decays exponentially until it reaches zero.
//  - Sits between a neuron's spike output and the next neuron's Isyn input.
//  - The weight is loaded through a valid/ready handshake.
// PARAMETERS
//  WEIGHT_INIT  8'd16  weight value after reset
//  TAU          2      decay shift: decay step = Isyn >> TAU
//  DECAY_DIV    4      cycles between decay ticks (>=1)
//  DELAY        3      delay-line depth in cycles (used only with SYN_DELAY_EN, >=1)
// PORTS
//  clk        in   1  clock, all logic on posedge
//  rst_n      in   1  synchronous reset, ACTIVE-HIGH despite the name
//  spike_in   in   1  presynaptic spike, 1-cycle pulse; consecutive-cycle pulses are legal
//  w_data     in   8  new weight
//  w_valid    in   1  weight load request
//  w_ready    out  1  weight register can accept
//  Isyn       out  8  synaptic current, registered
//  active     out  1  high while state==ACTIVE, registered
//  spike_cnt  out  8  received-spike counter, wraps 255->0
// BEHAVIOUR
//  Reset (rst_n==1 at posedge) takes priority over everything.
//   - Outputs: Isyn=0, active=0, spike_cnt=0, w_ready=1.
//   - Internal: weight=WEIGHT_INIT, prescaler=0, state=IDLE, delay line cleared.
//   - Reset mid-decay or mid-handshake aborts it; no partial update survives.
//  Weight handshake:
//   - Transfer occurs when w_valid & w_ready at a posedge: weight<=w_data.
//   - w_ready drops for the next cycle, then returns to 1 (max one load per 2 cycles).
//   - A spike in the accept cycle uses the OLD weight; the new weight applies
//     from the following cycle.
//  Prescaler:
//   - Counts 0..DECAY_DIV-1 only in ACTIVE and is held at 0 in IDLE.
//   - tick=1 in the cycle where the count is DECAY_DIV-1; the count then wraps to 0.
//   - Entering ACTIVE restarts the count at 0.
//  Isyn next-value, evaluated in this order:
//   1. d = Isyn>>TAU; if tick: Isyn' = Isyn - (d ? d : (Isyn!=0)).
//      Forcing a minimum step of 1 guarantees decay reaches 0.
//   2. If the effective spike is present: Isyn' = min(Isyn' + weight, 8'hFF),
//      computed in 9 bits and saturated, never wrapped.
//   - Spike and tick in the same cycle: decay first, then add.
//  Latency: spike sampled at edge N -> Isyn visible after edge N (1 cycle).
//  FSM, 2 states, one-hot or binary:
//   - IDLE -> ACTIVE when the effective spike is present and weight!=0.
//   - ACTIVE -> IDLE when Isyn'==0.
//   - A spike with weight==0 is counted but causes no state change and no Isyn change.
//  spike_cnt increments on every effective spike, whatever the weight.
// CONFIGURATION
//  SYN_DELAY_EN defined:
//   - spike_in passes through a DELAY-stage shift register (axonal delay);
//     the effective spike is the last stage.
//   - spike_cnt counts delayed spikes.
//   - Latency is DELAY+1 cycles from spike_in to Isyn.
//  SYN_DELAY_EN undefined:
//   - The effective spike is spike_in, DELAY is ignored, no delay registers exist.
// STRUCTURE
//  snn_pkg:
//   - syn_state_t {IDLE, ACTIVE}
//   - ISYN_W=8, ISYN_MAX=8'hFF
//   - shared saturating-add function, which the lif neuron also uses
//  Sub-module spike_delay_line: parameter DEPTH; ports clk, rst_n, d, q.
//   Instantiated only under SYN_DELAY_EN.
// TESTING
//  1. Reset, then spike_in at cycle 0 (weight 16, TAU 2, DIV 4)
//     -> Isyn=16, active=1 next cycle; after 4 cycles 12, then 9,7,6,5,4,3,2,1,0
//     at 4-cycle spacing; active=0 on reaching 0.
//  2. w_data=200 loaded; spikes on 2 consecutive cycles
//     -> Isyn=200, then 255 (saturated), spike_cnt=2.
//  3. w_valid=1 with 0x40 and a spike in the same cycle
//     -> Isyn+=16 (old weight), w_ready=0 for 1 cycle;
//     next spike adds 64; a second w_valid while w_ready=0 is held off.
//  4. Load weight 0, then spike -> Isyn stays 0, active stays 0, spike_cnt increments.
//  5. Isyn=100 in ACTIVE, assert rst_n for 1 cycle
//     -> Isyn=0, active=0, spike_cnt=0, w_ready=1, weight=16.
//  6. SYN_DELAY_EN, DELAY=3: spike at cycle N -> Isyn first nonzero after edge N+3;
//     reset at N+1 -> spike is lost.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network blocks (synapse, lif neuron).
// Holds the synapse state encoding, current width and the saturating adder.
package snn_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} syn_state_t;

   localparam int              ISYN_W   = 8;
   localparam logic [ISYN_W-1:0] ISYN_MAX = 8'hFF;

   // One extra bit catches the carry so the result clamps instead of wrapping.
   function automatic logic [ISYN_W-1:0] sat_add(input logic [ISYN_W-1:0] a,
                                                 input logic [ISYN_W-1:0] b);
      logic [ISYN_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[ISYN_W] ? ISYN_MAX : sum[ISYN_W-1:0];
   endfunction

endpackage

// File: rtl/spike_delay_line.sv
// Axonal delay: DEPTH-stage shift register, output is the oldest stage.
// Used by spike_synapse only when SYN_DELAY_EN is defined.
module spike_delay_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stage_p;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         stage_p <= '0;
      end else begin
         stage_p <= (stage_p << 1) | DEPTH'(d);
      end
   end

   assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/spike_synapse.sv
// Spike-to-current synapse: weighted spike accumulation with exponential decay.
// Optional axonal delay on spike_in when the SYN_DELAY_EN macro is defined.
module spike_synapse
   import snn_pkg::*;
#(
   parameter logic [7:0] WEIGHT_INIT = 8'd16,
   parameter int         TAU         = 2,
   parameter int         DECAY_DIV   = 4,
   parameter int         DELAY       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spike_in,
   input  logic [7:0] w_data,
   input  logic       w_valid,
   output logic       w_ready,
   output logic [7:0] Isyn,
   output logic       active,
   output logic [7:0] spike_cnt
);

   localparam int             PW         = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(DECAY_DIV - 1);
   localparam logic [0:0]     ST_IDLE    = IDLE;
   localparam logic [0:0]     ST_ACTIVE  = ACTIVE;

   logic [0:0]        state, state_nxt;
   logic [PW-1:0]     presc, presc_nxt;
   logic [7:0]        weight;
   logic              spike_eff;
   logic              tick;
   logic              add_en;
   logic [ISYN_W-1:0] isyn_dec, isyn_nxt;

   // Minimum step of 1 once the shifted value underflows, so decay always ends at 0.
   function automatic logic [ISYN_W-1:0] decay_step(input logic [ISYN_W-1:0] cur);
      logic [ISYN_W-1:0] d;
      d = cur >> TAU;
      if (d != '0) return d;
      return {{(ISYN_W-1){1'b0}}, (cur != '0)};
   endfunction

`ifdef SYN_DELAY_EN
   spike_delay_line #(
      .DEPTH (DELAY)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (spike_in),
      .q     (spike_eff)
   );
`else
   logic unused_delay_cfg;
   assign unused_delay_cfg = (DELAY >= 1);
   assign spike_eff        = spike_in;
`endif

   assign active = (state == ST_ACTIVE);
   assign tick   = active && (presc == PRESC_LAST);
   assign add_en = spike_eff && (weight != 8'd0);

   always_comb begin
      isyn_dec  = tick ? (Isyn - decay_step(Isyn)) : Isyn;
      isyn_nxt  = add_en ? sat_add(isyn_dec, weight) : isyn_dec;
      state_nxt = state;
      case (state)
         ST_IDLE:   if (add_en) state_nxt = ST_ACTIVE;
         default:   if (isyn_nxt == '0) state_nxt = ST_IDLE;
      endcase
      // Counting only continues while staying in ACTIVE; entry starts from 0.
      presc_nxt = '0;
      if (state == ST_ACTIVE && state_nxt == ST_ACTIVE) begin
         presc_nxt = tick ? '0 : presc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= ST_IDLE;
         presc     <= '0;
         Isyn      <= '0;
         spike_cnt <= '0;
         weight    <= WEIGHT_INIT;
         w_ready   <= 1'b1;
      end else begin
         state     <= state_nxt;
         presc     <= presc_nxt;
         Isyn      <= isyn_nxt;
         if (spike_eff) spike_cnt <= spike_cnt + 8'd1;
         // Accept holds w_ready low for exactly one cycle.
         if (w_valid && w_ready) begin
            weight  <= w_data;
            w_ready <= 1'b0;
         end else begin
            w_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spike_synapse.sv
// Scoreboard bench for spike_synapse: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares. Delay-line vectors apply under SYN_DELAY_EN.
module tb_spike_synapse;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spike_in = 1'b0;
   logic [7:0] w_data = 8'd0;
   logic       w_valid = 1'b0;
   logic       w_ready;
   logic [7:0] Isyn;
   logic       active;
   logic [7:0] spike_cnt;

   typedef struct {
      logic [7:0] isyn;
      logic       act;
      logic [7:0] cnt;
      logic       rdy;
      logic [3:0] mask;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   localparam logic [3:0] ALL = 4'b1111;
   localparam logic [3:0] CNT = 4'b0010;

   spike_synapse dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spike_in  (spike_in),
      .w_data    (w_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .Isyn      (Isyn),
      .active    (active),
      .spike_cnt (spike_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.mask[3]) begin
            n_cmp++;
            if (Isyn !== e.isyn) begin
               n_fail++;
               $display("FAIL %s.Isyn got %0d expected %0d", e.name, Isyn, e.isyn);
            end
         end
         if (e.mask[2]) begin
            n_cmp++;
            if (active !== e.act) begin
               n_fail++;
               $display("FAIL %s.active got %0b expected %0b", e.name, active, e.act);
            end
         end
         if (e.mask[1]) begin
            n_cmp++;
            if (spike_cnt !== e.cnt) begin
               n_fail++;
               $display("FAIL %s.spike_cnt got %0d expected %0d", e.name, spike_cnt, e.cnt);
            end
         end
         if (e.mask[0]) begin
            n_cmp++;
            if (w_ready !== e.rdy) begin
               n_fail++;
               $display("FAIL %s.w_ready got %0b expected %0b", e.name, w_ready, e.rdy);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the next posedge.
   task automatic step(input logic sp, input logic wv, input logic [7:0] wd, input logic r,
                       input logic [7:0] ei, input logic ea, input logic [7:0] ec,
                       input logic er, input logic [3:0] m, input string nm);
      exp_t e;
      @(negedge clk);
      #1;
      spike_in = sp;
      w_valid  = wv;
      w_data   = wd;
      rst_n    = r;
      e.isyn = ei; e.act = ea; e.cnt = ec; e.rdy = er; e.mask = m; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input string nm);
      step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, ALL, nm);
   endtask

   initial begin
      logic [7:0] dec_tbl [10];
      dec_tbl = '{8'd12, 8'd9, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

      do_reset("reset");
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "reset_idle");

`ifndef SYN_DELAY_EN
      // Single spike with default weight, then full decay to zero.
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd16, 1'b1, 8'd1, 1'b1, ALL, "t1_spike");
      repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0, 8'd16, 1'b1, 8'd1, 1'b1, ALL, "t1_hold16");
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 8'd0, 1'b0, dec_tbl[i], dec_tbl[i] != 8'd0, 8'd1, 1'b1, ALL, "t1_decay");
         if (dec_tbl[i] != 8'd0)
            repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0, dec_tbl[i], 1'b1, 8'd1, 1'b1, ALL, "t1_hold");
      end
      repeat (2) step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, ALL, "t1_idle");

      // Weight 200, two back-to-back spikes saturate at 255.
      do_reset("t2_reset");
      step(1'b0, 1'b1, 8'd200, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, ALL, "t2_load");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd200, 1'b1, 8'd1, 1'b1, ALL, "t2_spike1");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd255, 1'b1, 8'd2, 1'b1, ALL, "t2_sat");

      // Spike in the accept cycle uses the old weight; load while not ready is ignored.
      do_reset("t3_reset");
      step(1'b1, 1'b1, 8'h40, 1'b0, 8'd16, 1'b1, 8'd1, 1'b0, ALL, "t3_accept");
      step(1'b1, 1'b1, 8'h99, 1'b0, 8'd80, 1'b1, 8'd2, 1'b1, ALL, "t3_newweight");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd144, 1'b1, 8'd3, 1'b1, ALL, "t3_heldoff");

      // Zero weight: counted but no current and no activation.
      do_reset("t4_reset");
      step(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, ALL, "t4_load0");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, ALL, "t4_spike");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd2, 1'b1, ALL, "t4_spike2");

      // Reset while active restores weight 16; spike coinciding with a tick.
      do_reset("t5_reset");
      step(1'b0, 1'b1, 8'd100, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, ALL, "t5_load");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd100, 1'b1, 8'd1, 1'b1, ALL, "t5_spike");
      step(1'b1, 1'b1, 8'd7, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "t5_midreset");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd16, 1'b1, 8'd1, 1'b1, ALL, "t5_weight16");
      repeat (2) step(1'b0, 1'b0, 8'd0, 1'b0, 8'd16, 1'b1, 8'd1, 1'b1, ALL, "t5_hold");
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd16, 1'b1, 8'd1, 1'b1, ALL, "t5_hold3");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd28, 1'b1, 8'd2, 1'b1, ALL, "t5_tick_spike");

      // Counter wraps 255 -> 0.
      do_reset("wrap_reset");
      step(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, ALL, "wrap_load0");
      for (int i = 0; i < 256; i++)
         step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'(i + 1), 1'b1, CNT, "wrap_cnt");
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "wrap_zero");
`else
      // Delayed spike reaches Isyn after edge N+3.
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "t6_n0");
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "t6_n1");
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "t6_n2");
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd16, 1'b1, 8'd1, 1'b1, ALL, "t6_n3");
      // Reset one cycle after the spike flushes it from the delay line.
      do_reset("t6_reset");
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "t6_spike");
      step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "t6_flush");
      repeat (4) step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, ALL, "t6_lost");
`endif

      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 4'b0000, "drain");
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain pending %0d expected 0", exp_q.size());
      end
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
